asynch_fifo_rd_packer: RTL and testbench

//  Read-side consumer of the asynchronous FIFO. Runs in the read clock domain.

---
 rtl/asynch_fifo_pkg.sv | 16 +
 rtl/rd_packer_idle_timer.sv | 32 +++
 rtl/asynch_fifo_rd_packer.sv | 124 ++++++++++++
 tb/tb_asynch_fifo_rd_packer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/asynch_fifo_pkg.sv
// Shared types and defaults for the asynchronous FIFO read-side packer.
// RD_PACKER_FLUSH_EN adds the idle-flush timeout default.
package asynch_fifo_pkg;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } rd_packer_state_e;

    localparam int FIFO_WIDTH_DEF     = 4;
    localparam int PACK_RATIO_DEF     = 4;
`ifdef RD_PACKER_FLUSH_EN
    localparam int TIMEOUT_CYCLES_DEF = 16;
`endif

endpackage

// File: rtl/rd_packer_idle_timer.sv
// Idle-cycle counter with clear and terminal count for the packer's partial-word flush.
// Only built when RD_PACKER_FLUSH_EN is defined.
`ifdef RD_PACKER_FLUSH_EN
module rd_packer_idle_timer #(
    parameter int  LIMIT = 16,
    localparam int CNT_W = $clog2(LIMIT + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic tc_o
);

    logic [CNT_W-1:0] cnt_q;

    // Fires on the LIMIT-th consecutive idle cycle.
    assign tc_o = inc_i && (cnt_q == CNT_W'(LIMIT - 1));

    // Idle-cycle count, restarted whenever activity resumes or the flush fires.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= {CNT_W{1'b0}};
        end else if (clr_i || tc_o) begin
            cnt_q <= {CNT_W{1'b0}};
        end else if (inc_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule
`endif

// File: rtl/asynch_fifo_rd_packer.sv
// Read-side packer: pops FIFO entries and packs PACK_RATIO of them per output word.
// Defining RD_PACKER_FLUSH_EN enables the idle-timeout flush of partial words.
module asynch_fifo_rd_packer
    import asynch_fifo_pkg::*;
#(
    parameter int  FIFO_WIDTH     = FIFO_WIDTH_DEF,
    parameter int  PACK_RATIO     = PACK_RATIO_DEF,
`ifdef RD_PACKER_FLUSH_EN
    parameter int  TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
`endif
    localparam int OUT_WIDTH      = FIFO_WIDTH * PACK_RATIO,
    localparam int CNT_W          = $clog2(PACK_RATIO + 1)
) (
    input  logic                  i_rclk,
    input  logic                  i_rst,
    input  logic                  i_empty,
    output logic                  o_ren,
    input  logic [FIFO_WIDTH-1:0] i_rdata,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [OUT_WIDTH-1:0]  o_data,
    output logic [CNT_W-1:0]      o_nib_cnt,
    output logic                  o_partial
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(PACK_RATIO);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PACK_RATIO - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    rd_packer_state_e     state_q;
    logic [CNT_W-1:0]     iss_cnt_q;
    logic [CNT_W-1:0]     cap_cnt_q;
    logic                 rd_pend_q;
    logic [OUT_WIDTH-1:0] data_d;
    logic                 flush_s;

    // iss_cnt caps reads in flight so a word never over-collects.
    assign o_ren = !i_rst && (state_q == COLLECT) && !i_empty && (iss_cnt_q < FULL_CNT);

    // Unfilled slots are always zero, so OR-ing the entry in places it at cap_cnt.
    assign data_d = o_data | (OUT_WIDTH'(i_rdata) << (int'(cap_cnt_q) * FIFO_WIDTH));

`ifdef RD_PACKER_FLUSH_EN
    logic idle_s;
    logic partial_q;

    assign idle_s = (state_q == COLLECT) && (cap_cnt_q != {CNT_W{1'b0}}) && !o_ren && !rd_pend_q;

    rd_packer_idle_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk_i (i_rclk),
        .rst_i (i_rst),
        .clr_i (!idle_s),
        .inc_i (idle_s),
        .tc_o  (flush_s)
    );

    // Marks a flushed word short until downstream takes it.
    always_ff @(posedge i_rclk or posedge i_rst) begin
        if (i_rst) begin
            partial_q <= 1'b0;
        end else if (flush_s) begin
            partial_q <= 1'b1;
        end else if ((state_q == HOLD) && i_ready) begin
            partial_q <= 1'b0;
        end
    end

    assign o_partial = partial_q;
`else
    assign flush_s   = 1'b0;
    assign o_partial = 1'b0;
`endif

    // Read bookkeeping, word assembly and the COLLECT/HOLD handshake.
    always_ff @(posedge i_rclk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= COLLECT;
            iss_cnt_q <= {CNT_W{1'b0}};
            cap_cnt_q <= {CNT_W{1'b0}};
            rd_pend_q <= 1'b0;
            o_valid   <= 1'b0;
            o_data    <= {OUT_WIDTH{1'b0}};
            o_nib_cnt <= {CNT_W{1'b0}};
        end else begin
            rd_pend_q <= o_ren;
            case (state_q)
                COLLECT: begin
                    if (o_ren) begin
                        iss_cnt_q <= iss_cnt_q + ONE_CNT;
                    end
                    if (rd_pend_q) begin
                        o_data    <= data_d;
                        cap_cnt_q <= cap_cnt_q + ONE_CNT;
                        if (cap_cnt_q == LAST_CNT) begin
                            state_q   <= HOLD;
                            o_valid   <= 1'b1;
                            o_nib_cnt <= FULL_CNT;
                        end
                    end else if (flush_s) begin
                        state_q   <= HOLD;
                        o_valid   <= 1'b1;
                        o_nib_cnt <= cap_cnt_q;
                    end
                end
                HOLD: begin
                    if (i_ready) begin
                        state_q   <= COLLECT;
                        o_valid   <= 1'b0;
                        iss_cnt_q <= {CNT_W{1'b0}};
                        cap_cnt_q <= {CNT_W{1'b0}};
                        o_data    <= {OUT_WIDTH{1'b0}};
                        o_nib_cnt <= {CNT_W{1'b0}};
                    end
                end
                default: begin
                    state_q <= COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_asynch_fifo_rd_packer.sv
// Randomized bench for asynch_fifo_rd_packer against a queue-based FIFO and word model.
// Flush expectations follow RD_PACKER_FLUSH_EN.
module tb_asynch_fifo_rd_packer;

    localparam int PR = 4;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_empty;
    logic        o_ren;
    logic [3:0]  i_rdata;
    logic        o_valid;
    logic        i_ready;
    logic [15:0] o_data;
    logic [2:0]  o_nib_cnt;
    logic        o_partial;

    logic [3:0]  fifo[$];
    logic [3:0]  word_ents[$];
    bit          gap = 1'b0;
    bit          hold_active = 1'b0;
    bit          acc_prev = 1'b0;
    bit          last_ren = 1'b0;
    int          cyc = 0;
    int          last_ren_cyc = 0;
    int          words = 0;
    int          w0;
    int          ren_cnt;
    logic [15:0] held_w = 16'h0000;
    logic [15:0] last_word = 16'h0000;
    int          total = 0;
    int          bad = 0;

    asynch_fifo_rd_packer dut (
        .i_rclk    (clk),
        .i_rst     (i_rst),
        .i_empty   (i_empty),
        .o_ren     (o_ren),
        .i_rdata   (i_rdata),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_data    (o_data),
        .o_nib_cnt (o_nib_cnt),
        .o_partial (o_partial)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: observe at the falling edge, let the FIFO model pop at the rising edge.
    task automatic tick();
        logic        ren;
        logic [15:0] exp_w;
        i_empty = gap || (fifo.size() == 0);
        @(negedge clk);
        cyc++;
        ren = o_ren;
        last_ren = ren;
        if (acc_prev) begin
            check_val("valid_drop", o_valid, 1'b0);
            check_val("data_clr", o_data, 16'h0000);
            if (!i_empty) check_val("ren_after_acc", o_ren, 1'b1);
        end
        if (ren) begin
            check_val("ren_not_empty", i_empty, 1'b0);
            check_val("ren_in_hold", o_valid, 1'b0);
            check_val("ren_overrun", word_ents.size() < PR, 1'b1);
            word_ents.push_back(fifo[0]);
            if (word_ents.size() == PR) last_ren_cyc = cyc;
        end
        if (o_valid && !hold_active) begin
            exp_w = 16'h0000;
            foreach (word_ents[i]) exp_w = exp_w | (16'(word_ents[i]) << (4 * i));
            check_val("word_data", o_data, exp_w);
            check_val("word_cnt", o_nib_cnt, word_ents.size());
            check_val("word_partial", o_partial, word_ents.size() < PR);
            if (word_ents.size() == PR) check_val("latency", cyc - last_ren_cyc, 2);
            hold_active = 1'b1;
            held_w = o_data;
            last_word = o_data;
            words++;
        end else if (o_valid) begin
            check_val("hold_data", o_data, held_w);
        end
        acc_prev = o_valid && i_ready;
        if (acc_prev) begin
            hold_active = 1'b0;
            word_ents.delete();
        end
        @(posedge clk);
        #1;
        if (ren && fifo.size() > 0) i_rdata = fifo.pop_front();
        else i_rdata = 4'($urandom);
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        fifo.delete();
        word_ents.delete();
        hold_active = 1'b0;
        acc_prev = 1'b0;
        @(negedge clk);
        check_val("mid_rst_ren", o_ren, 1'b0);
        check_val("mid_rst_valid", o_valid, 1'b0);
        @(posedge clk);
        #1;
        i_rst = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1;
        i_empty = 1'b0;
        i_ready = 1'b0;
        i_rdata = 4'h0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_val("rst_ren", o_ren, 1'b0);
        check_val("rst_valid", o_valid, 1'b0);
        check_val("rst_data", o_data, 16'h0000);
        check_val("rst_partial", o_partial, 1'b0);
        check_val("rst_cnt", o_nib_cnt, 3'd0);
        @(posedge clk);
        #1;
        i_rst = 1'b0;

        // Back-to-back entries, downstream always ready.
        i_ready = 1'b1;
        fifo.push_back(4'h1); fifo.push_back(4'h2); fifo.push_back(4'h3); fifo.push_back(4'h4);
        ren_cnt = 0;
        repeat (4) begin tick(); ren_cnt += int'(last_ren); end
        check_val("t2_ren_run", ren_cnt, 4);
        w0 = words;
        repeat (6) tick();
        check_val("t2_words", words - w0, 1);
        check_val("t2_data", last_word, 16'h4321);

        // Downstream stalls with more entries waiting.
        i_ready = 1'b0;
        fifo.push_back(4'h5); fifo.push_back(4'h6); fifo.push_back(4'h7); fifo.push_back(4'h8);
        fifo.push_back(4'h1); fifo.push_back(4'h1); fifo.push_back(4'h1); fifo.push_back(4'h1);
        for (int k = 0; k < 12 && !hold_active; k++) tick();
        check_val("t3_hold", hold_active, 1'b1);
        ren_cnt = 0;
        repeat (10) begin tick(); ren_cnt += int'(last_ren); end
        check_val("t3_no_ren", ren_cnt, 0);
        check_val("t3_data", last_word, 16'h8765);
        i_ready = 1'b1;
        tick();
        tick();
        repeat (10) tick();

        // Empty gaps between entries.
        fifo.push_back(4'hA); fifo.push_back(4'hB); fifo.push_back(4'hC); fifo.push_back(4'hD);
        w0 = words;
        for (int k = 0; k < 4; k++) begin
            gap = 1'b0;
            tick();
            gap = 1'b1;
            repeat (3) tick();
        end
        gap = 1'b0;
        repeat (4) tick();
        check_val("t4_words", words - w0, 1);
        check_val("t4_data", last_word, 16'hDCBA);

        // Reset with a half-built word.
        fifo.push_back(4'h3); fifo.push_back(4'h4);
        repeat (5) tick();
        do_reset();
        fifo.push_back(4'h9); fifo.push_back(4'h8); fifo.push_back(4'h7); fifo.push_back(4'h6);
        w0 = words;
        repeat (10) tick();
        check_val("t5_words", words - w0, 1);
        check_val("t5_data", last_word, 16'h6789);

        // Random traffic, gaps and back-pressure.
        w0 = words;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(3) != 0 && fifo.size() < 16) fifo.push_back(4'($urandom));
            gap = ($urandom_range(4) == 0);
            i_ready = ($urandom_range(2) != 0);
            tick();
        end
        gap = 1'b0;
        i_ready = 1'b1;
        repeat (30) tick();
        check_val("rand_words", words - w0 > 20, 1'b1);
        do_reset();

        // Two entries, then the FIFO runs dry.
        w0 = words;
        fifo.push_back(4'h5); fifo.push_back(4'h6);
        repeat (2) tick();
        gap = 1'b1;
        repeat (40) tick();
`ifdef RD_PACKER_FLUSH_EN
        check_val("t6_words", words - w0, 1);
        check_val("t6_data", last_word, 16'h0065);
`else
        check_val("t6_words", words - w0, 0);
        check_val("t6_valid", o_valid, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
